// File: rtl/pipeline_clock_controller.sv
// rtl/pipeline_clock_controller.sv - debug sequencer gating the MIPS pipeline clock-enable
module pipeline_clock_controller #(
  parameter logic [31:0] HALT_INSTR = 32'hFFFFFFFF,
  parameter logic [7:0]  CMD_RUN    = 8'h63,
  parameter logic [7:0]  CMD_STEP   = 8'h73,
  parameter logic [7:0]  CMD_STEPN  = 8'h6E,
  parameter logic [7:0]  CMD_PAUSE  = 8'h70,
  parameter logic [7:0]  CMD_DUMP   = 8'h64,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx_empty,
  input  logic [7:0]           rx_data,
  output logic                 rx_rd,
  input  logic [31:0]          instruction,
  output logic                 pipeline_en,
  output logic                 dump_start,
  input  logic                 dump_done,
  output logic                 halted,
  output logic [2:0]           state_debug,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_N     = 3'd1,
    STEP      = 3'd2,
    STEPN     = 3'd3,
    RUN       = 3'd4,
    DUMP_REQ  = 3'd5,
    DUMP_WAIT = 3'd6,
    HALTED    = 3'd7
  } state_t;

  state_t     state;
  logic [7:0] step_cnt;
  logic       halt_hit;
  logic       run_state;
  logic       pop_state;
  logic       pause_pop;

  // Decode halt, pop permission and the clock-enable from the current state
  always_comb begin
    halt_hit    = (instruction == HALT_INSTR);
    run_state   = (state == STEP) || (state == STEPN) || (state == RUN);
    pop_state   = (state == IDLE) || (state == GET_N) || (state == RUN) || (state == HALTED);
    rx_rd       = !rx_empty && pop_state;
    pause_pop   = (state == RUN) && rx_rd && (rx_data == CMD_PAUSE);
    // HALT word must never be clocked past IF, so it masks the enable in the same cycle
    pipeline_en = run_state && !halt_hit && !pause_pop;
    dump_start  = (state == DUMP_REQ);
    state_debug = state;
  end

  // Command sequencer: every stop funnels through DUMP_REQ exactly once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      step_cnt <= 8'd0;
      halted   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_rd) begin
            case (rx_data)
              CMD_RUN:   state <= RUN;
              CMD_STEP:  state <= STEP;
              CMD_STEPN: state <= GET_N;
              CMD_DUMP:  state <= DUMP_REQ;
              default:   state <= IDLE;
            endcase
          end
        end
        GET_N: begin
          if (rx_rd) begin
            step_cnt <= rx_data;
            state    <= (rx_data == 8'd0) ? DUMP_REQ : STEPN;
          end
        end
        STEP: begin
          if (halt_hit) halted <= 1'b1;
          state <= DUMP_REQ;
        end
        STEPN: begin
          if (halt_hit) begin
            halted <= 1'b1;
            state  <= DUMP_REQ;
          end else begin
            step_cnt <= step_cnt - 8'd1;
            if (step_cnt == 8'd1) state <= DUMP_REQ;
          end
        end
        RUN: begin
          if (halt_hit) begin
            halted <= 1'b1;
            state  <= DUMP_REQ;
          end else if (pause_pop) begin
            state <= DUMP_REQ;
          end
        end
        DUMP_REQ: state <= DUMP_WAIT;
        DUMP_WAIT: begin
          if (dump_done) state <= halted ? HALTED : IDLE;
        end
        HALTED: begin
          if (rx_rd && (rx_data == CMD_DUMP)) state <= DUMP_REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Count enabled pipeline cycles, wrapping naturally at the counter width
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count <= '0;
    end else if (pipeline_en) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_clock_controller.sv
// tb/tb_pipeline_clock_controller.sv - randomized scenario bench for pipeline_clock_controller
module tb_pipeline_clock_controller;

  localparam int          CW   = 4;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic          clock;
  logic          reset_n;
  logic          rx_empty;
  logic [7:0]    rx_data;
  logic          rx_rd;
  logic [31:0]   instruction;
  logic          pipeline_en;
  logic          dump_start;
  logic          dump_done;
  logic          halted;
  logic [2:0]    state_debug;
  logic [CW-1:0] cycle_count;

  pipeline_clock_controller #(.CNT_WIDTH(CW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .rx_rd       (rx_rd),
    .instruction (instruction),
    .pipeline_en (pipeline_en),
    .dump_start  (dump_start),
    .dump_done   (dump_done),
    .halted      (halted),
    .state_debug (state_debug),
    .cycle_count (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo[$];
  bit en_q[$];
  bit ds_q[$];
  bit rd_q[$];
  int  model_cc = 0;
  int  dd_cnt = -1;
  bit  dd_auto = 1'b1;
  bit  dd_level = 1'b0;
  bit  force_halt = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] v;
    v = $urandom;
    if (v == HALT) v = 32'h0;
    return v;
  endfunction

  function automatic int count_q(input bit q[$]);
    int n = 0;
    foreach (q[i]) if (q[i]) n++;
    return n;
  endfunction

  task automatic drive_rx();
    rx_empty = (fifo.size() == 0);
    rx_data  = rx_empty ? 8'h00 : fifo[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    drive_rx();
  endtask

  task automatic clear_logs();
    en_q.delete();
    ds_q.delete();
    rd_q.delete();
  endtask

  // one clock: observe at negedge, emulate FIFO pop / TX sequencer just after posedge
  task automatic tick();
    bit pop;
    @(negedge clock);
    en_q.push_back(pipeline_en);
    ds_q.push_back(dump_start);
    rd_q.push_back(rx_rd);
    pop = rx_rd;
    if (dump_start) dd_cnt = $urandom_range(0, 3);
    @(posedge clock);
    #1;
    if (pop && fifo.size() > 0) void'(fifo.pop_front());
    dump_done = dd_level;
    if (dd_auto && dd_cnt == 0) dump_done = 1'b1;
    if (dd_cnt >= 0) dd_cnt--;
    instruction = force_halt ? HALT : rand_instr();
    drive_rx();
  endtask

  task automatic run_until(input int n_dumps, input int limit);
    int seen = count_q(ds_q);
    int t = 0;
    while (seen < n_dumps && t < limit) begin
      tick();
      if (ds_q[$]) seen++;
      t++;
    end
    if (seen < n_dumps) check("timeout_dump", seen, n_dumps);
    repeat (6) tick();
  endtask

  task automatic scn_check(input string tag, input int exp_en, input int exp_dump,
                           input bit exp_halt, input bit contig);
    int n_en = 0;
    int first = -1;
    int last = -1;
    foreach (en_q[i]) if (en_q[i]) begin
      n_en++;
      if (first < 0) first = i;
      last = i;
    end
    model_cc = (model_cc + exp_en) % (1 << CW);
    check($sformatf("%s_en", tag), n_en, exp_en);
    check($sformatf("%s_dump", tag), count_q(ds_q), exp_dump);
    if (contig && exp_en > 0) check($sformatf("%s_contig", tag), last - first + 1, exp_en);
    check($sformatf("%s_halted", tag), halted, exp_halt);
    check($sformatf("%s_state", tag), state_debug, exp_halt ? 7 : 0);
    check($sformatf("%s_cc", tag), cycle_count, model_cc);
    clear_logs();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fifo.delete();
    drive_rx();
    dump_done  = 1'b0;
    dd_cnt     = -1;
    dd_level   = 1'b0;
    force_halt = 1'b0;
    instruction = rand_instr();
    #2;
    check("rst_en", pipeline_en, 0);
    check("rst_ds", dump_start, 0);
    check("rst_rd", rx_rd, 0);
    check("rst_halted", halted, 0);
    check("rst_state", state_debug, 0);
    check("rst_cc", cycle_count, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_cc = 0;
    clear_logs();
  endtask

  task automatic scn_run(input string tag, input int r, input bit with_x);
    int xpos = $urandom_range(0, r - 1);
    push(8'h63);
    tick();
    for (int i = 0; i < r; i++) begin
      if (with_x && i == xpos) push(8'h78);
      tick();
    end
    push(8'h70);
    tick();
    check($sformatf("%s_pause_rd", tag), rd_q[$], 1);
    check($sformatf("%s_pause_en", tag), en_q[$], 0);
    run_until(1, 20);
    scn_check(tag, r, 1, 1'b0, 1'b1);
  endtask

  initial begin
    int n, h, kind;
    reset_n = 1'b0;
    rx_empty = 1'b1;
    rx_data = 8'h00;
    instruction = 32'h0;
    dump_done = 1'b0;
    repeat (2) @(posedge clock);
    do_reset();

    // single step with cycle-exact latency
    push(8'h73);
    tick();
    check("step_pop", rd_q[$], 1);
    check("step_en_pop", en_q[$], 0);
    tick();
    check("step_en", en_q[$], 1);
    tick();
    check("step_ds", ds_q[$], 1);
    check("step_en_after", en_q[$], 0);
    run_until(1, 20);
    scn_check("step", 1, 1, 1'b0, 1'b1);

    push(8'h6E); push(8'h05);
    run_until(1, 30);
    scn_check("stepn5", 5, 1, 1'b0, 1'b1);

    push(8'h6E); push(8'h00);
    run_until(1, 30);
    scn_check("stepn0", 0, 1, 1'b0, 1'b1);

    push(8'h64);
    run_until(1, 20);
    scn_check("dump_only", 0, 1, 1'b0, 1'b0);

    dd_level = 1'b1;
    push(8'h73);
    run_until(1, 20);
    dd_level = 1'b0;
    scn_check("level_done", 1, 1, 1'b0, 1'b1);

    // bytes queued behind a stepn are held during the dump and run in order
    push(8'h41); push(8'h6E); push(8'h03); push(8'h73); push(8'h6E); push(8'h02);
    run_until(3, 100);
    scn_check("queued", 6, 3, 1'b0, 1'b0);

    for (int it = 0; it < 6; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        n = $urandom_range(0, 12);
        if ($urandom_range(0, 1) == 1) push(8'(8'h41 + $urandom_range(0, 25)));
        push(8'h6E); push(8'(n));
        run_until(1, n + 20);
        scn_check($sformatf("rnd_stepn%0d", n), n, 1, 1'b0, 1'b1);
      end else if (kind == 1) begin
        scn_run("rnd_run", $urandom_range(2, 15), 1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 1) == 1) push(8'(8'h41 + $urandom_range(0, 25)));
        push(8'h73);
        run_until(1, 20);
        scn_check("rnd_step", 1, 1, 1'b0, 1'b1);
      end
    end

    // halt during RUN, optionally colliding with a pause
    h = $urandom_range(1, 10);
    push(8'h63);
    tick();
    repeat (h) tick();
    force_halt = 1'b1;
    instruction = HALT;
    if ($urandom_range(0, 1) == 1) push(8'h70);
    tick();
    check("halt_run_en0", en_q[$], 0);
    check("halt_run_flag", halted, 1);
    run_until(1, 20);
    scn_check("halt_run", h, 1, 1'b1, 1'b1);
    force_halt = 1'b0;
    instruction = rand_instr();
    push(8'h73);
    repeat (4) tick();
    check("halted_s_pop", count_q(rd_q), 1);
    scn_check("halted_s", 0, 0, 1'b1, 1'b0);
    push(8'h64);
    run_until(1, 20);
    scn_check("halted_d", 0, 1, 1'b1, 1'b0);

    // halt on the final STEPN cycle wins over counter expiry
    do_reset();
    n = $urandom_range(3, 10);
    push(8'h6E); push(8'(n));
    tick();
    tick();
    repeat (n - 1) tick();
    force_halt = 1'b1;
    instruction = HALT;
    tick();
    check("halt_stepn_en0", en_q[$], 0);
    run_until(1, 20);
    scn_check("halt_stepn", n - 1, 1, 1'b1, 1'b1);

    // asynchronous reset mid-RUN
    do_reset();
    push(8'h63);
    repeat (6) tick();
    check("mrun_state", state_debug, 4);
    check("mrun_en", pipeline_en, 1);
    do_reset();

    // asynchronous reset mid-DUMP_WAIT, no dump afterwards
    dd_auto = 1'b0;
    push(8'h64);
    repeat (3) tick();
    check("mdw_state", state_debug, 6);
    do_reset();
    dd_auto = 1'b1;
    repeat (5) tick();
    check("mdw_nodump", count_q(ds_q), 0);
    check("mdw_state_after", state_debug, 0);
    clear_logs();

    // 20 enabled cycles on a 4-bit counter wraps to 4
    scn_run("wrap", 20, 1'b0);
    check("wrap_cc", cycle_count, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
